// File: rtl/branch_predict_unit_if.sv
// Fetch/execute bus of the branch prediction unit: lookup, resolution inputs,
// redirect and performance counters. The predictor side uses the slave modport.
interface branch_predict_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] if_pc;
  logic            if_pred_taken;
  logic [XLEN-1:0] if_pred_target;

  logic            ex_valid;
  logic            ex_branch;
  logic            ex_jal;
  logic            ex_jalr;
  logic [2:0]      ex_branch_type;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_imm;
  logic [XLEN-1:0] ex_pc;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pred_target;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [31:0]     perf_branches;
  logic [31:0]     perf_mispred;

  modport master (
    output if_pc,
    output ex_valid, ex_branch, ex_jal, ex_jalr, ex_branch_type,
    output ex_rs1_data, ex_rs2_data, ex_imm, ex_pc,
    output ex_pred_taken, ex_pred_target,
    input  if_pred_taken, if_pred_target,
    input  redirect_valid, redirect_pc,
    input  perf_branches, perf_mispred
  );

  modport slave (
    input  if_pc,
    input  ex_valid, ex_branch, ex_jal, ex_jalr, ex_branch_type,
    input  ex_rs1_data, ex_rs2_data, ex_imm, ex_pc,
    input  ex_pred_taken, ex_pred_target,
    output if_pred_taken, if_pred_target,
    output redirect_valid, redirect_pc,
    output perf_branches, perf_mispred
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB plus saturating-counter BHT: combinational fetch lookup,
// execute-side branch resolution, mispredict redirect, table training and event counters.
module branch_predict_unit #(
  parameter int XLEN     = 32,
  parameter int BHT_IDX  = 6,
  parameter int CTR_BITS = 2,
  parameter int TAG_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  branch_predict_unit_if.slave bus
);

  localparam int DEPTH  = 1 << BHT_IDX;
  localparam int TAG_LO = BHT_IDX + 2;
  localparam int TAG_HI = TAG_LO + TAG_BITS - 1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_MIN  = '0;

  logic                r_valid  [DEPTH];
  logic [TAG_BITS-1:0] r_tag    [DEPTH];
  logic [XLEN-1:0]     r_target [DEPTH];
  logic [CTR_BITS-1:0] r_ctr    [DEPTH];
  logic [31:0]         r_perf_branches;
  logic [31:0]         r_perf_mispred;

  logic [BHT_IDX-1:0]  w_if_idx;
  logic [TAG_BITS-1:0] w_if_tag;
  logic                w_if_hit;
  logic                w_if_taken;

  logic [BHT_IDX-1:0]  w_ex_idx;
  logic [TAG_BITS-1:0] w_ex_tag;
  logic                w_is_jal;
  logic                w_is_jalr;
  logic                w_is_br;
  logic                w_resolve;
  logic                w_train;
  logic                w_cond;
  logic                w_taken;
  logic [XLEN-1:0]     w_jalr_sum;
  logic [XLEN-1:0]     w_target;
  logic [XLEN-1:0]     w_fallthrough;
  logic                w_mispredict;
  logic                w_redirect;
  logic [CTR_BITS-1:0] w_ctr_cur;
  logic [CTR_BITS-1:0] w_ctr_next;
  logic                w_unused_ok;

  // Fetch lookup reads the registered tables, so a same-cycle update is not seen yet.
  assign w_if_idx   = bus.if_pc[BHT_IDX+1:2];
  assign w_if_tag   = bus.if_pc[TAG_HI:TAG_LO];
  assign w_if_hit   = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign w_if_taken = w_if_hit && r_ctr[w_if_idx][CTR_BITS-1];

  assign bus.if_pred_taken  = w_if_taken;
  assign bus.if_pred_target = w_if_taken ? r_target[w_if_idx] : '0;

  // JAL wins over JALR, which wins over a conditional branch, when several flags are set.
  assign w_is_jal  = bus.ex_jal;
  assign w_is_jalr = bus.ex_jalr & ~bus.ex_jal;
  assign w_is_br   = bus.ex_branch & ~bus.ex_jal & ~bus.ex_jalr;
  assign w_resolve = bus.ex_valid & (w_is_jal | w_is_jalr | w_is_br);
  assign w_train   = bus.ex_valid & (w_is_jal | w_is_br);

  always_comb begin
    w_cond = 1'b0;
    case (bus.ex_branch_type)
      3'b000:  w_cond = (bus.ex_rs1_data == bus.ex_rs2_data);
      3'b001:  w_cond = (bus.ex_rs1_data != bus.ex_rs2_data);
      3'b100:  w_cond = ($signed(bus.ex_rs1_data) <  $signed(bus.ex_rs2_data));
      3'b101:  w_cond = ($signed(bus.ex_rs1_data) >= $signed(bus.ex_rs2_data));
      3'b110:  w_cond = (bus.ex_rs1_data <  bus.ex_rs2_data);
      3'b111:  w_cond = (bus.ex_rs1_data >= bus.ex_rs2_data);
      default: w_cond = 1'b0;
    endcase
  end

  assign w_taken       = w_is_jal | w_is_jalr | (w_is_br & w_cond);
  assign w_jalr_sum    = bus.ex_rs1_data + bus.ex_imm;
  assign w_target      = w_is_jalr ? (w_jalr_sum & ~XLEN'(1)) : (bus.ex_pc + bus.ex_imm);
  assign w_fallthrough = bus.ex_pc + XLEN'(4);
  assign w_mispredict  = (w_taken != bus.ex_pred_taken) |
                         (w_taken & (w_target != bus.ex_pred_target));
  assign w_redirect    = w_resolve & w_mispredict;

  assign bus.redirect_valid = w_redirect;
  assign bus.redirect_pc    = w_redirect ? (w_taken ? w_target : w_fallthrough) : '0;

  assign w_ex_idx  = bus.ex_pc[BHT_IDX+1:2];
  assign w_ex_tag  = bus.ex_pc[TAG_HI:TAG_LO];
  assign w_ctr_cur = r_ctr[w_ex_idx];

  always_comb begin
    w_ctr_next = w_ctr_cur;
    if (w_taken) begin
      if (w_ctr_cur != CTR_MAX) w_ctr_next = w_ctr_cur + CTR_BITS'(1);
    end else begin
      if (w_ctr_cur != CTR_MIN) w_ctr_next = w_ctr_cur - CTR_BITS'(1);
    end
  end

  // Valid bits, counters and perf counters clear in a single reset edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= CTR_INIT;
      end
      r_perf_branches <= '0;
      r_perf_mispred  <= '0;
    end else begin
      if (w_train) begin
        r_ctr[w_ex_idx] <= w_ctr_next;
        if (w_taken) r_valid[w_ex_idx] <= 1'b1;
      end
      if (w_resolve)  r_perf_branches <= r_perf_branches + 32'd1;
      if (w_redirect) r_perf_mispred  <= r_perf_mispred + 32'd1;
    end
  end

  // Tag and target are qualified by the valid bit, so they need no reset.
  always_ff @(posedge clk) begin
    if (rst_n && w_train && w_taken) begin
      r_tag[w_ex_idx]    <= w_ex_tag;
      r_target[w_ex_idx] <= w_target;
    end
  end

  assign bus.perf_branches = r_perf_branches;
  assign bus.perf_mispred  = r_perf_mispred;

  assign w_unused_ok = &{1'b0, bus.if_pc[1:0], bus.if_pc[XLEN-1:TAG_HI+1]};

endmodule

// File: tb/tb_branch_predict_unit.sv
// Randomized scoreboard bench for branch_predict_unit: a table-level reference model
// predicts every cycle's outputs, and a monitor compares them at the falling edge.
module tb_branch_predict_unit;

  localparam int XLEN     = 32;
  localparam int BHT_IDX  = 6;
  localparam int CTR_BITS = 2;
  localparam int TAG_BITS = 8;
  localparam int DEPTH    = 1 << BHT_IDX;
  localparam int CTR_TOP  = (1 << CTR_BITS) - 1;
  localparam int CTR_HALF = 1 << (CTR_BITS - 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_predict_unit_if #(.XLEN(XLEN)) bus ();

  branch_predict_unit #(
    .XLEN(XLEN), .BHT_IDX(BHT_IDX), .CTR_BITS(CTR_BITS), .TAG_BITS(TAG_BITS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] ifPc;
    bit          exValid;
    bit          exBranch;
    bit          exJal;
    bit          exJalr;
    logic [2:0]  bt;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    bit          predTaken;
    logic [31:0] predTarget;
  } stim_t;

  typedef struct {
    int          id;
    bit          predTaken;
    logic [31:0] predTarget;
    bit          redirValid;
    logic [31:0] redirPc;
    logic [31:0] perfBr;
    logic [31:0] perfMis;
  } expect_t;

  expect_t sbQueue[$];
  int checks = 0;
  int errors = 0;
  int seq = 0;

  bit                mValid  [DEPTH];
  logic [TAG_BITS-1:0] mTag  [DEPTH];
  logic [31:0]       mTarget [DEPTH];
  int                mCtr    [DEPTH];
  logic [31:0]       mBr;
  logic [31:0]       mMis;

  function automatic int idxOf(input logic [31:0] pc);
    return int'((pc >> 2) & 32'(DEPTH - 1));
  endfunction

  function automatic logic [TAG_BITS-1:0] tagOf(input logic [31:0] pc);
    logic [31:0] t;
    t = (pc >> (BHT_IDX + 2)) & 32'((1 << TAG_BITS) - 1);
    return t[TAG_BITS-1:0];
  endfunction

  function automatic void modelLookup(input logic [31:0] pc, output bit t, output logic [31:0] tgt);
    int i;
    i = idxOf(pc);
    t = mValid[i] && (mTag[i] == tagOf(pc)) && (mCtr[i] >= CTR_HALF);
    tgt = t ? mTarget[i] : 32'h0;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) begin
      mValid[i] = 1'b0;
      mCtr[i]   = CTR_HALF - 1;
    end
    mBr  = 32'h0;
    mMis = 32'h0;
  endtask

  function automatic stim_t mkStim(input logic [31:0] ifPc, input bit v, input bit br, input bit jal,
                                   input bit jalr, input logic [2:0] bt, input logic [31:0] rs1,
                                   input logic [31:0] rs2, input logic [31:0] imm, input logic [31:0] pc,
                                   input bit pt, input logic [31:0] ptg);
    stim_t s;
    s.ifPc = ifPc; s.exValid = v; s.exBranch = br; s.exJal = jal; s.exJalr = jalr;
    s.bt = bt; s.rs1 = rs1; s.rs2 = rs2; s.imm = imm; s.pc = pc;
    s.predTaken = pt; s.predTarget = ptg;
    return s;
  endfunction

  function automatic stim_t idle(input logic [31:0] ifPc);
    return mkStim(ifPc, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
  endfunction

  function automatic stim_t branch(input logic [31:0] ifPc, input logic [2:0] bt, input logic [31:0] rs1,
                                   input logic [31:0] rs2, input logic [31:0] imm, input logic [31:0] pc,
                                   input bit pt, input logic [31:0] ptg);
    return mkStim(ifPc, 1'b1, 1'b1, 1'b0, 1'b0, bt, rs1, rs2, imm, pc, pt, ptg);
  endfunction

  // Drive one cycle, queue what the outputs must show during it, then advance the model.
  task automatic applyStimulus(input stim_t s, input bit rstn);
    expect_t e;
    bit ctrl, taken, cond, train;
    logic [31:0] target;
    int i;

    rst_n                = rstn;
    bus.if_pc            = s.ifPc;
    bus.ex_valid         = s.exValid;
    bus.ex_branch        = s.exBranch;
    bus.ex_jal           = s.exJal;
    bus.ex_jalr          = s.exJalr;
    bus.ex_branch_type   = s.bt;
    bus.ex_rs1_data      = s.rs1;
    bus.ex_rs2_data      = s.rs2;
    bus.ex_imm           = s.imm;
    bus.ex_pc            = s.pc;
    bus.ex_pred_taken    = s.predTaken;
    bus.ex_pred_target   = s.predTarget;

    e.id = seq;
    seq++;
    modelLookup(s.ifPc, e.predTaken, e.predTarget);

    case (s.bt)
      3'b000:  cond = (s.rs1 == s.rs2);
      3'b001:  cond = (s.rs1 != s.rs2);
      3'b100:  cond = ($signed(s.rs1) < $signed(s.rs2));
      3'b101:  cond = ($signed(s.rs1) >= $signed(s.rs2));
      3'b110:  cond = (s.rs1 < s.rs2);
      3'b111:  cond = (s.rs1 >= s.rs2);
      default: cond = 1'b0;
    endcase

    if (s.exJal) begin
      taken = 1'b1; target = s.pc + s.imm;
    end else if (s.exJalr) begin
      taken = 1'b1; target = (s.rs1 + s.imm) & 32'hFFFF_FFFE;
    end else begin
      taken = s.exBranch && cond; target = s.pc + s.imm;
    end
    ctrl  = s.exValid && (s.exJal || s.exJalr || s.exBranch);
    train = s.exValid && (s.exJal || (s.exBranch && !s.exJalr));

    e.redirValid = ctrl && ((taken != s.predTaken) || (taken && target != s.predTarget));
    e.redirPc    = e.redirValid ? (taken ? target : s.pc + 32'd4) : 32'h0;
    e.perfBr     = mBr;
    e.perfMis    = mMis;
    sbQueue.push_back(e);

    if (!rstn) begin
      modelReset();
    end else if (ctrl) begin
      mBr++;
      if (e.redirValid) mMis++;
      if (train) begin
        i = idxOf(s.pc);
        mCtr[i] = taken ? ((mCtr[i] < CTR_TOP) ? mCtr[i] + 1 : CTR_TOP)
                        : ((mCtr[i] > 0) ? mCtr[i] - 1 : 0);
        if (taken) begin
          mValid[i]  = 1'b1;
          mTag[i]    = tagOf(s.pc);
          mTarget[i] = target;
        end
      end
    end

    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle=%0d actual=%h expected=%h", name, id, act, exp);
    end
  endtask

  // Monitor: consumes one queued expectation per falling edge.
  initial begin
    expect_t e;
    forever begin
      @(negedge clk);
      if (sbQueue.size() > 0) begin
        e = sbQueue.pop_front();
        checkOutput("pred_taken",     e.id, 32'(bus.if_pred_taken),  32'(e.predTaken));
        checkOutput("pred_target",    e.id, bus.if_pred_target,      e.predTarget);
        checkOutput("redirect_valid", e.id, 32'(bus.redirect_valid), 32'(e.redirValid));
        checkOutput("redirect_pc",    e.id, bus.redirect_pc,         e.redirPc);
        checkOutput("perf_branches",  e.id, bus.perf_branches,       e.perfBr);
        checkOutput("perf_mispred",   e.id, bus.perf_mispred,        e.perfMis);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [31:0] pickPc();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0100;
      1: return 32'h0000_0200;
      2: return 32'h0000_0104;
      3: return 32'h0000_0140;
      4: return 32'h0000_0300;
      5: return 32'hFFFF_FFFC;
      6: return 32'h0000_1100;
      default: return $urandom() & 32'h0000_FFFC;
    endcase
  endfunction

  function automatic logic [31:0] pickOp();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h5;
      3: return 32'hFFFF_FFFF;
      4: return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [31:0] pickImm();
    case ($urandom_range(0, 4))
      0: return 32'h20;
      1: return 32'h8;
      2: return 32'hFFFF_FFFC;
      3: return 32'h40;
      default: return $urandom() & 32'hFFFF_FFFE;
    endcase
  endfunction

  initial begin
    stim_t s;
    bit pt;
    logic [31:0] ptg;
    int kind;

    bus.if_pc = '0; bus.ex_valid = 1'b0; bus.ex_branch = 1'b0; bus.ex_jal = 1'b0;
    bus.ex_jalr = 1'b0; bus.ex_branch_type = '0; bus.ex_rs1_data = '0; bus.ex_rs2_data = '0;
    bus.ex_imm = '0; bus.ex_pc = '0; bus.ex_pred_taken = 1'b0; bus.ex_pred_target = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();

    applyStimulus(idle(32'h0000_0100), 1'b1);
    applyStimulus(idle(32'h1234_5678), 1'b1);
    applyStimulus(branch(32'h100, 3'b000, 32'd5, 32'd5, 32'h20, 32'h100, 1'b0, 32'h0), 1'b1);
    applyStimulus(idle(32'h0000_0100), 1'b1);
    applyStimulus(branch(32'h100, 3'b000, 32'd5, 32'd5, 32'h20, 32'h100, 1'b1, 32'h120), 1'b1);
    applyStimulus(branch(32'h100, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 1'b1, 32'h120), 1'b1);
    applyStimulus(branch(32'h100, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 1'b1, 32'h120), 1'b1);
    applyStimulus(idle(32'h0000_0100), 1'b1);
    applyStimulus(mkStim(32'h300, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h203, 32'h0, 32'h4, 32'h300,
                         1'b0, 32'h0), 1'b1);
    applyStimulus(idle(32'h0000_0300), 1'b1);
    applyStimulus(branch(32'h100, 3'b000, 32'd1, 32'd1, 32'h20, 32'h200, 1'b0, 32'h0), 1'b1);
    applyStimulus(idle(32'h0000_0100), 1'b1);
    applyStimulus(idle(32'h0000_0200), 1'b1);
    applyStimulus(branch(32'h104, 3'b010, 32'd1, 32'd1, 32'h20, 32'h104, 1'b1, 32'h124), 1'b1);
    applyStimulus(mkStim(32'h500, 1'b1, 1'b1, 1'b1, 1'b1, 3'b000, 32'h0, 32'h1, 32'h40, 32'h500,
                         1'b0, 32'h0), 1'b1);
    applyStimulus(idle(32'h0000_0500), 1'b1);
    applyStimulus(branch(32'h200, 3'b000, 32'd0, 32'd0, 32'h10, 32'h400, 1'b0, 32'h0), 1'b0);
    applyStimulus(idle(32'h0000_0200), 1'b1);
    applyStimulus(idle(32'h0000_0400), 1'b1);
    applyStimulus(branch(32'h0, 3'b000, 32'd0, 32'd0, 32'h8, 32'hFFFF_FFFC, 1'b0, 32'h0), 1'b1);

    for (int n = 0; n < 500; n++) begin
      s = idle(pickPc());
      kind = $urandom_range(0, 9);
      s.exValid  = (kind != 9);
      s.exBranch = (kind >= 1 && kind <= 5) || (kind >= 8 && $urandom_range(0, 1) == 1);
      s.exJal    = (kind == 6) || (kind >= 8 && $urandom_range(0, 1) == 1);
      s.exJalr   = (kind == 7) || (kind >= 8 && $urandom_range(0, 1) == 1);
      s.bt       = 3'($urandom_range(0, 7));
      s.rs1      = pickOp();
      s.rs2      = ($urandom_range(0, 3) == 0) ? s.rs1 : pickOp();
      s.imm      = pickImm();
      s.pc       = pickPc();
      if ($urandom_range(0, 1) == 1) s.ifPc = s.pc;
      if ($urandom_range(0, 1) == 1) begin
        modelLookup(s.pc, pt, ptg);
        s.predTaken = pt;
        s.predTarget = ptg;
      end else begin
        s.predTaken = 1'($urandom_range(0, 1));
        s.predTarget = ($urandom_range(0, 1) == 1) ? s.pc + s.imm : $urandom();
      end
      applyStimulus(s, ($urandom_range(0, 63) != 0));
    end

    applyStimulus(idle(32'h0000_0100), 1'b1);
    @(negedge clk);
    #1;
    checks++;
    if (sbQueue.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain actual=%0d expected=0", sbQueue.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
